fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised successor to the single-register fetch stage. Decouples a multi-cycle,
//  pipelined instruction memory from decode: issues in-order fetch requests with a
//  bounded number outstanding, buffers returned words in a prefetch FIFO with their PCs,
//  and feeds decode one {instruction, prog_counter} per unstalled cycle.
//  Branch redirect flushes the FIFO and silently discards in-flight responses.
//  Sits between the instruction memory and the decode stage.
// PARAMETERS
//  DEPTH      4             prefetch FIFO entries (power of two, >=2)
//  MAX_OUT    2             max outstanding memory requests (1..DEPTH)
//  ADDR_W     32            PC / word-address width
//  INSTR_W    32            instruction width
//  RESET_PC   0             PC fetched first after reset
//  NOP_INSTR  32'h21000000  bubble word driven to decode (addi r0, r0, 0)
// PORTS
//  clock         in   1        sole clock, rising edge
//  reset         in   1        asynchronous, active-high
//  req_valid     out  1        fetch request valid
//  req_ready     in   1        memory accepts request this cycle
//  req_addr      out  ADDR_W   word address of request
//  resp_valid    in   1        response word valid (in request order, >=1 cycle after accept)
//  resp_instr    in   INSTR_W  response word
//  data_stall    in   1        decode/EX stall: hold outputs
//  branch_taken  in   1        redirect request (from EX)
//  new_pc        in   ADDR_W   redirect target
//  instruction   out  INSTR_W  registered word to decode
//  prog_counter  out  ADDR_W   registered PC of instruction
//  instr_valid   out  1        instruction is real (0 = bubble)
//  fetch_stall   out  1        FIFO empty and decode wants a word (perf/debug)
// BEHAVIOUR
//  Reset: pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0,
//   instruction=NOP_INSTR, prog_counter=0, instr_valid=0, req_valid=0.
//  Request: req_valid = !branch_taken && outstanding<MAX_OUT && (count+outstanding)<DEPTH
//   (credit rule guarantees FIFO never overflows). req_addr=pc. On accept pc<=pc+1,
//   outstanding+1. Accept and response same cycle: net outstanding unchanged.
//  Response: if discard>0: drop word, discard-1, outstanding-1. Else push
//   {resp_pc,resp_instr}, resp_pc+1, outstanding-1.
//  Output (registered, 1-cycle latency FIFO->decode): when !data_stall: FIFO non-empty ->
//   pop head into instruction/prog_counter, instr_valid=1; empty -> instruction=NOP_INSTR,
//   instr_valid=0, prog_counter held. When data_stall: all outputs and FIFO head held.
//  Bypass: response arriving into empty FIFO is visible to decode next cycle (push and
//   pop same cycle allowed; FIFO full + push never occurs).
//  Branch (priority over data_stall and everything else): pc<=new_pc+0 and request
//   suppressed this cycle; resp_pc<=new_pc; FIFO cleared; instruction<=NOP_INSTR,
//   instr_valid<=0; discard<=outstanding_next (all in-flight, incl. a response arriving
//   this cycle, are dropped). First request to new_pc issues next cycle.
//  Back-to-back branches: each reloads pc/discard; discard never underflows.
//  pc/resp_pc wrap modulo 2^ADDR_W. fetch_stall = !data_stall && FIFO empty.
//  Reset asserted mid-transaction: all state returns to reset values immediately; the
//   memory is reset by the same signal, so no stale response is expected afterwards.
// STRUCTURE
//  cpu_pkg: NOP_INSTR default, INSTR_W/ADDR_W constants, fetch_entry_t {pc,instr} typedef.
//  Sub-module fetch_fifo #(WIDTH,DEPTH): sync FIFO, push/pop/clear, count, full/empty,
//   async reset; clear wins over push. Rest (pc, credits, discard, output reg) in top.
// TESTING
//  1 Reset, req_ready=1, 1-cycle memory -> addrs 0,1,2.. issued, decode sees pc 0,1,2 with
//    instr_valid=1 every cycle from cycle 3.
//  2 req_ready=0 for 5 cycles -> req_addr stays 0, instruction=NOP_INSTR, instr_valid=0.
//  3 data_stall high 6 cycles, 1-cycle memory, DEPTH=4 -> at most 4 words buffered,
//    req_valid drops; release -> pcs resume in order, none lost or duplicated.
//  4 3-cycle memory, MAX_OUT=2, branch_taken new_pc=0x40 with 2 in flight -> both
//    responses dropped, next valid output pc=0x40 with word at 0x40.
//  5 branch_taken with data_stall=1 -> flush still happens, NOP_INSTR output next cycle.
//  6 reset pulsed asynchronously mid-fetch -> outputs at reset values before next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the buffered {pc, instr} entry type.
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W  = 32;
   localparam int unsigned CPU_INSTR_W = 32;

   // addi r0, r0, 0 : bubble word handed to decode
   localparam logic [CPU_INSTR_W-1:0] CPU_NOP_INSTR = 32'h2100_0000;

   typedef struct packed {
      logic [CPU_ADDR_W-1:0]  pc;
      logic [CPU_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with clear; clear wins over push and pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !clear && !full;
   assign do_pop  = pop && !clear && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: credit-limited in-order requests, prefetch FIFO, decode register.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned        DEPTH     = 4,
   parameter int unsigned        MAX_OUT   = 2,
   parameter int unsigned        ADDR_W    = CPU_ADDR_W,
   parameter int unsigned        INSTR_W   = CPU_INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(CPU_NOP_INSTR)
) (
   input  logic               clock,
   input  logic               reset,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [ADDR_W-1:0]  req_addr,
   input  logic               resp_valid,
   input  logic [INSTR_W-1:0] resp_instr,
   input  logic               data_stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  new_pc,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  prog_counter,
   output logic               instr_valid,
   output logic               fetch_stall
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  resp_pc;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   outstanding_next;
   logic [OUT_W-1:0]   discard;
   logic               accept;
   logic               keep_word;
   logic               do_pop;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENT_W-1:0]   fifo_rdata;
   logic [ENT_W-1:0]   pop_word;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   // Credit rule: buffered + in-flight words never exceed the FIFO depth
   assign req_valid = !reset && !branch_taken
                      && (outstanding < OUT_W'(MAX_OUT))
                      && ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
   assign req_addr  = pc;
   assign accept    = req_valid && req_ready;

   // A response is kept only when nothing is pending discard and no redirect is underway
   assign keep_word = resp_valid && (discard == '0) && !branch_taken;
   assign do_pop    = !branch_taken && !data_stall && (!fifo_empty || keep_word);
   // Word arriving into an empty FIFO while decode takes one goes straight to the output
   assign fifo_push = keep_word && !fifo_full && !(fifo_empty && do_pop);
   assign fifo_pop  = do_pop && !fifo_empty;
   assign pop_word  = fifo_empty ? {resp_pc, resp_instr} : fifo_rdata;

   assign fetch_stall = !data_stall && fifo_empty;

   // In-flight request count after this cycle's accept/response
   always_comb begin
      outstanding_next = outstanding;
      if (accept && !resp_valid)      outstanding_next = outstanding + OUT_W'(1);
      else if (!accept && resp_valid) outstanding_next = outstanding - OUT_W'(1);
   end

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (branch_taken),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({resp_pc, resp_instr}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Request PC, response PC, credit and discard bookkeeping; redirect reloads all of it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (branch_taken) begin
            pc      <= new_pc;
            resp_pc <= new_pc;
            discard <= outstanding_next;
         end else begin
            if (accept) pc <= pc + ADDR_W'(1);
            if (resp_valid) begin
               if (discard != '0) discard <= discard - OUT_W'(1);
               else               resp_pc <= resp_pc + ADDR_W'(1);
            end
         end
      end
   end

   // Decode-facing register; redirect flush beats stall, stall holds everything
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instruction  <= NOP_INSTR;
         prog_counter <= '0;
         instr_valid  <= 1'b0;
      end else if (branch_taken) begin
         instruction <= NOP_INSTR;
         instr_valid <= 1'b0;
      end else if (!data_stall) begin
         if (do_pop) begin
            instruction  <= pop_word[INSTR_W-1:0];
            prog_counter <= pop_word[ENT_W-1:INSTR_W];
            instr_valid  <= 1'b1;
         end else begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
         end
      end
   end

endmodule
